// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB control FSM for the RV32I core.
// Drives memory handshakes, IR latch, RF write, PC update and retire count.
module core_sequencer #(
   parameter int MEM_TIMEOUT = 255,
   parameter int TIMEOUT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   output logic        imem_req,
   input  logic        imem_ack,
   output logic        ir_load,
   input  logic        dec_reg_write,
   input  logic        dec_mem_read,
   input  logic        dec_mem_write,
   input  logic        dec_branch,
   input  logic        dec_jump,
   input  logic        dec_illegal,
   input  logic        branch_taken,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   output logic        rf_write,
   output logic        pc_write,
   output logic [1:0]  pc_sel,
   output logic        retire,
   output logic [31:0] instret,
   output logic        fault,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      DECODE  = 3'd2,
      EXECUTE = 3'd3,
      MEM     = 3'd4,
      WB      = 3'd5,
      FAULT   = 3'd6
   } state_t;

   localparam logic [TIMEOUT_W-1:0] WAIT_LAST =
      TIMEOUT_W'(MEM_TIMEOUT - 1);

   state_t               st;
   logic [TIMEOUT_W-1:0] wait_cnt;
   logic                 r_reg_write;
   logic                 r_mem_acc;
   logic                 r_mem_write;
   logic                 r_branch;
   logic                 r_jump;
   logic                 r_br_taken;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st          <= IDLE;
         wait_cnt    <= '0;
         instret     <= '0;
         r_reg_write <= 1'b0;
         r_mem_acc   <= 1'b0;
         r_mem_write <= 1'b0;
         r_branch    <= 1'b0;
         r_jump      <= 1'b0;
         r_br_taken  <= 1'b0;
      end else begin
         case (st)
            IDLE: begin
               if (run) begin
                  st       <= FETCH;
                  wait_cnt <= '0;
               end
            end
            FETCH: begin
               // an ack on the final wait cycle still wins over the timeout
               if (imem_ack)
                  st <= DECODE;
               else if (wait_cnt == WAIT_LAST)
                  st <= FAULT;
               else
                  wait_cnt <= wait_cnt + 1'b1;
            end
            DECODE: begin
               r_reg_write <= dec_reg_write;
               r_mem_acc   <= dec_mem_read | dec_mem_write;
               r_mem_write <= dec_mem_write;
               r_branch    <= dec_branch;
               r_jump      <= dec_jump;
               st          <= dec_illegal ? FAULT : EXECUTE;
            end
            EXECUTE: begin
               r_br_taken <= r_branch & branch_taken;
               if (r_mem_acc) begin
                  st       <= MEM;
                  wait_cnt <= '0;
               end else begin
                  st <= WB;
               end
            end
            MEM: begin
               if (dmem_ack)
                  st <= WB;
               else if (wait_cnt == WAIT_LAST)
                  st <= FAULT;
               else
                  wait_cnt <= wait_cnt + 1'b1;
            end
            WB: begin
               instret <= instret + 32'd1;
               if (run) begin
                  st       <= FETCH;
                  wait_cnt <= '0;
               end else begin
                  st <= IDLE;
               end
            end
            FAULT:   st <= FAULT;
            default: st <= FAULT;
         endcase
      end
   end

   logic in_wb;

   assign in_wb    = (st == WB);
   assign imem_req = (st == FETCH);
   assign ir_load  = imem_req & imem_ack;
   assign dmem_req = (st == MEM);
   assign dmem_we  = dmem_req & r_mem_write;
   assign rf_write = in_wb & r_reg_write;
   assign pc_write = in_wb;
   assign retire   = in_wb;
   assign pc_sel   = !in_wb    ? 2'b00 :
                     r_jump     ? 2'b10 :
                     r_br_taken ? 2'b01 : 2'b00;
   assign fault    = (st == FAULT);
   assign state    = st;

endmodule
